// File: rtl/micro_udp_engine_tx_arb.sv
// Two-source packet arbiter merging the ARP and UDP transmit streams onto one
// MAC-facing stream. A grant is taken at a start-of-packet beat and held until
// the end-of-packet beat is transferred, so packets are never interleaved.
// Beats that arrive mid-packet while no grant is held are discarded and counted.
module micro_udp_engine_tx_arb #(
    parameter int ARP_STRICT_PRIO = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] arp_tx_data,
    input  logic [4:0]   arp_tx_empty,
    input  logic         arp_tx_startofpacket,
    input  logic         arp_tx_endofpacket,
    input  logic         arp_tx_valid,
    output logic         arp_tx_ready,
    input  logic [255:0] udp_tx_data,
    input  logic [4:0]   udp_tx_empty,
    input  logic         udp_tx_startofpacket,
    input  logic         udp_tx_endofpacket,
    input  logic         udp_tx_valid,
    output logic         udp_tx_ready,
    output logic [255:0] l4_tx_data,
    output logic [4:0]   l4_tx_empty,
    output logic         l4_tx_startofpacket,
    output logic         l4_tx_endofpacket,
    output logic         l4_tx_valid,
    input  logic         l4_tx_ready,
    output logic [31:0]  pkt_cnt_arp,
    output logic [31:0]  pkt_cnt_udp,
    output logic [15:0]  drop_cnt,
    output logic         grant_arp,
    output logic         grant_udp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_ARP = 2'd1,
        GNT_UDP = 2'd2
    } state_t;

    state_t state_reg, state_next;
    // 1 = ARP held the most recent grant, 0 = UDP did
    logic   last_gnt_arp_reg, last_gnt_arp_next;

    // Per-source views, bit 0 = ARP, bit 1 = UDP
    logic [1:0] src_valid, src_sop, src_eop;
    logic [1:0] src_req, src_stray, src_grant, src_done, idle_stray;
    logic       pick_arp;

    logic [31:0] pkt_cnt_reg [2];
    logic [15:0] drop_cnt_reg;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    assign src_valid = {udp_tx_valid, arp_tx_valid};
    assign src_sop   = {udp_tx_startofpacket, arp_tx_startofpacket};
    assign src_eop   = {udp_tx_endofpacket, arp_tx_endofpacket};
    assign src_req   = src_valid & src_sop;
    assign src_stray = src_valid & ~src_sop;
    assign src_grant = {state_reg == GNT_UDP, state_reg == GNT_ARP};
    assign src_done  = src_grant & src_valid & src_eop & {2{l4_tx_ready}};
    assign idle_stray = src_stray & {2{state_reg == IDLE}};

    // On a tie ARP wins when strict, otherwise whoever was not granted last
    assign pick_arp = (ARP_STRICT_PRIO != 0) || !last_gnt_arp_reg;

    // State and round-robin pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            last_gnt_arp_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            last_gnt_arp_reg <= last_gnt_arp_next;
        end
    end

    // Next-state: arbitrate from IDLE, release a grant after the last beat moves
    always_comb begin
        state_next        = state_reg;
        last_gnt_arp_next = last_gnt_arp_reg;
        case (state_reg)
            IDLE: begin
                if (src_req[0] && (!src_req[1] || pick_arp)) begin
                    state_next        = GNT_ARP;
                    last_gnt_arp_next = 1'b1;
                end else if (src_req[1]) begin
                    state_next        = GNT_UDP;
                    last_gnt_arp_next = 1'b0;
                end
            end
            GNT_ARP: if (src_done[0]) state_next = IDLE;
            GNT_UDP: if (src_done[1]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output mux: pass the granted source through; in IDLE only swallow strays.
    // Readies are gated by reset_n so they fall the instant reset asserts.
    always_comb begin
        l4_tx_data          = '0;
        l4_tx_empty         = '0;
        l4_tx_startofpacket = 1'b0;
        l4_tx_endofpacket   = 1'b0;
        l4_tx_valid         = 1'b0;
        arp_tx_ready        = 1'b0;
        udp_tx_ready        = 1'b0;
        case (state_reg)
            IDLE: begin
                arp_tx_ready = src_stray[0] & reset_n;
                udp_tx_ready = src_stray[1] & reset_n;
            end
            GNT_ARP: begin
                l4_tx_data          = arp_tx_data;
                l4_tx_empty         = arp_tx_empty;
                l4_tx_startofpacket = arp_tx_startofpacket;
                l4_tx_endofpacket   = arp_tx_endofpacket;
                l4_tx_valid         = arp_tx_valid;
                arp_tx_ready        = l4_tx_ready;
            end
            GNT_UDP: begin
                l4_tx_data          = udp_tx_data;
                l4_tx_empty         = udp_tx_empty;
                l4_tx_startofpacket = udp_tx_startofpacket;
                l4_tx_endofpacket   = udp_tx_endofpacket;
                l4_tx_valid         = udp_tx_valid;
                udp_tx_ready        = l4_tx_ready;
            end
            default: ;
        endcase
    end

    assign grant_arp = (state_reg == GNT_ARP);
    assign grant_udp = (state_reg == GNT_UDP);

    // Per-source forwarded-packet counters, wrapping at 2^32
    for (genvar gi = 0; gi < 2; gi++) begin : g_pkt_cnt
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pkt_cnt_reg[gi] <= '0;
            end else if (src_done[gi]) begin
                pkt_cnt_reg[gi] <= pkt_cnt_reg[gi] + 32'd1;
            end
        end
    end

    assign pkt_cnt_arp = pkt_cnt_reg[0];
    assign pkt_cnt_udp = pkt_cnt_reg[1];

    // Both sources may drop a stray beat in the same cycle, so add up to two
    assign drop_inc = {1'b0, idle_stray[0]} + {1'b0, idle_stray[1]};
    assign drop_sum = {1'b0, drop_cnt_reg} + {15'd0, drop_inc};

    // Saturating stray-beat counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_reg <= '0;
        end else begin
            drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_micro_udp_engine_tx_arb.sv
// Bench for micro_udp_engine_tx_arb: two instances (round-robin and ARP-strict)
// driven by queue-fed source players, checked every cycle against a
// packet-level model, plus directed scenarios with literal expectations.
module tb_micro_udp_engine_tx_arb;

    typedef struct {
        logic [255:0] data;
        logic [4:0]   empty;
        logic         sop;
        logic         eop;
        int           gap;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Source index = 2*dut + src, src 0 = ARP, 1 = UDP
    logic [255:0] s_data [4];
    logic [4:0]   s_empty [4];
    logic         s_sop [4];
    logic         s_eop [4];
    logic         s_valid [4];
    logic         s_ready [4];

    logic [255:0] l4_data [2];
    logic [4:0]   l4_empty [2];
    logic         l4_sop [2];
    logic         l4_eop [2];
    logic         l4_valid [2];
    logic         l4r [2];
    logic [31:0]  pkt_a [2];
    logic [31:0]  pkt_u [2];
    logic [15:0]  drop [2];
    logic         g_a [2];
    logic         g_u [2];

    beat_t src_q [4][$];

    int errors = 0;
    int checks = 0;

    // Model state: owner 0 = none, 1 = ARP, 2 = UDP
    int          m_owner [2];
    bit          m_last_arp [2];
    logic [31:0] m_pa [2];
    logic [31:0] m_pu [2];
    int          m_drop [2];
    int          fwd [2][2];
    int          mon_xfer [2];
    int          glog [2][$];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        micro_udp_engine_tx_arb #(.ARP_STRICT_PRIO(gi)) u_dut (
            .clk                  (clk),
            .reset_n              (rst_n),
            .arp_tx_data          (s_data[2*gi]),
            .arp_tx_empty         (s_empty[2*gi]),
            .arp_tx_startofpacket (s_sop[2*gi]),
            .arp_tx_endofpacket   (s_eop[2*gi]),
            .arp_tx_valid         (s_valid[2*gi]),
            .arp_tx_ready         (s_ready[2*gi]),
            .udp_tx_data          (s_data[2*gi+1]),
            .udp_tx_empty         (s_empty[2*gi+1]),
            .udp_tx_startofpacket (s_sop[2*gi+1]),
            .udp_tx_endofpacket   (s_eop[2*gi+1]),
            .udp_tx_valid         (s_valid[2*gi+1]),
            .udp_tx_ready         (s_ready[2*gi+1]),
            .l4_tx_data           (l4_data[gi]),
            .l4_tx_empty          (l4_empty[gi]),
            .l4_tx_startofpacket  (l4_sop[gi]),
            .l4_tx_endofpacket    (l4_eop[gi]),
            .l4_tx_valid          (l4_valid[gi]),
            .l4_tx_ready          (l4r[gi]),
            .pkt_cnt_arp          (pkt_a[gi]),
            .pkt_cnt_udp          (pkt_u[gi]),
            .drop_cnt             (drop[gi]),
            .grant_arp            (g_a[gi]),
            .grant_udp            (g_u[gi])
        );
    end

    // Source players: present queued beats in order, hold each until accepted
    for (genvar gi = 0; gi < 4; gi++) begin : g_src
        logic [255:0] d_r;
        logic [4:0]   e_r;
        logic         sop_r, eop_r, v_r;
        assign s_data[gi]  = d_r;
        assign s_empty[gi] = e_r;
        assign s_sop[gi]   = sop_r;
        assign s_eop[gi]   = eop_r;
        assign s_valid[gi] = v_r;
        initial begin
            beat_t b;
            logic  acc;
            v_r = 1'b0; d_r = '0; e_r = '0; sop_r = 1'b0; eop_r = 1'b0;
            @(posedge clk); #1;
            forever begin
                if (src_q[gi].size() == 0) begin
                    v_r = 1'b0;
                    @(posedge clk); #1;
                end else begin
                    b = src_q[gi].pop_front();
                    v_r = 1'b0;
                    repeat (b.gap) begin @(posedge clk); #1; end
                    d_r = b.data; e_r = b.empty; sop_r = b.sop; eop_r = b.eop; v_r = 1'b1;
                    acc = 1'b0;
                    while (!acc) begin
                        @(negedge clk);
                        acc = s_ready[gi];
                        @(posedge clk); #1;
                    end
                    v_r = 1'b0;
                end
            end
        end
    end

    task automatic chk(input int k, input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, name, act, exp, $time);
        end
    endtask

    // One cycle of the reference: expected outputs from the packet rules, then advance
    task automatic model_step(input int k);
        int a, u, src, pick, n;
        logic ev, era, eru, ega, egu;
        a = 2 * k;
        u = 2 * k + 1;
        if (!rst_n) begin
            chk(k, "rst_valid", l4_valid[k], 0);
            chk(k, "rst_rdy_arp", s_ready[a], 0);
            chk(k, "rst_rdy_udp", s_ready[u], 0);
            chk(k, "rst_gnt_arp", g_a[k], 0);
            chk(k, "rst_gnt_udp", g_u[k], 0);
            chk(k, "rst_pkt_arp", pkt_a[k], 0);
            chk(k, "rst_pkt_udp", pkt_u[k], 0);
            chk(k, "rst_drop", drop[k], 0);
            m_owner[k] = 0; m_last_arp[k] = 1'b0;
            m_pa[k] = '0; m_pu[k] = '0; m_drop[k] = 0;
            return;
        end
        src = (m_owner[k] == 2) ? u : a;
        if (m_owner[k] == 0) begin
            ev = 1'b0; ega = 1'b0; egu = 1'b0;
            era = s_valid[a] && !s_sop[a];
            eru = s_valid[u] && !s_sop[u];
        end else begin
            ev  = s_valid[src];
            ega = (m_owner[k] == 1);
            egu = (m_owner[k] == 2);
            era = ega ? l4r[k] : 1'b0;
            eru = egu ? l4r[k] : 1'b0;
        end
        chk(k, "gnt_arp", g_a[k], ega);
        chk(k, "gnt_udp", g_u[k], egu);
        chk(k, "l4_valid", l4_valid[k], ev);
        chk(k, "rdy_arp", s_ready[a], era);
        chk(k, "rdy_udp", s_ready[u], eru);
        if (m_owner[k] != 0) begin
            chk(k, "l4_data", l4_data[k], s_data[src]);
            chk(k, "l4_empty", l4_empty[k], s_empty[src]);
            chk(k, "l4_sop", l4_sop[k], s_sop[src]);
            chk(k, "l4_eop", l4_eop[k], s_eop[src]);
        end
        chk(k, "pkt_arp", pkt_a[k], m_pa[k]);
        chk(k, "pkt_udp", pkt_u[k], m_pu[k]);
        chk(k, "drop", drop[k], m_drop[k]);
        if (l4_valid[k] && l4r[k]) mon_xfer[k]++;
        if (m_owner[k] == 0) begin
            n = int'(era) + int'(eru);
            m_drop[k] = (m_drop[k] + n > 65535) ? 65535 : m_drop[k] + n;
            pick = 0;
            if (s_valid[a] && s_sop[a] && s_valid[u] && s_sop[u])
                pick = (k == 1 || !m_last_arp[k]) ? 1 : 2;
            else if (s_valid[a] && s_sop[a]) pick = 1;
            else if (s_valid[u] && s_sop[u]) pick = 2;
            if (pick != 0) begin
                m_owner[k] = pick;
                m_last_arp[k] = (pick == 1);
                glog[k].push_back(pick);
            end
        end else if (s_valid[src] && l4r[k]) begin
            fwd[k][m_owner[k]-1]++;
            if (s_eop[src]) begin
                if (m_owner[k] == 1) m_pa[k] = m_pa[k] + 1;
                else                 m_pu[k] = m_pu[k] + 1;
                $display("dut%0d forwarded %s packet, total %0d", k,
                         (m_owner[k] == 1) ? "ARP" : "UDP",
                         (m_owner[k] == 1) ? m_pa[k] : m_pu[k]);
                m_owner[k] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic push_pkt(input int idx, input int nb, input int gap, input bit first_sop);
        for (int i = 0; i < nb; i++) begin
            beat_t b;
            for (int j = 0; j < 8; j++) b.data[j*32 +: 32] = $urandom;
            b.empty = 5'($urandom_range(0, 31));
            b.sop   = first_sop && (i == 0);
            b.eop   = (i == nb - 1);
            b.gap   = (i == 0) ? gap : 0;
            src_q[idx].push_back(b);
        end
    endtask

    function automatic bit quiet();
        bit q;
        q = 1'b1;
        for (int i = 0; i < 4; i++) if (src_q[i].size() != 0 || s_valid[i]) q = 1'b0;
        for (int k = 0; k < 2; k++) if (g_a[k] || g_u[k]) q = 1'b0;
        return q;
    endfunction

    task automatic drain(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (n < limit && !quiet()) begin
            @(negedge clk);
            n++;
        end
        chk(0, "drain_in_time", n < limit, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        glog[0].delete();
        glog[1].delete();
        for (int k = 0; k < 2; k++) begin
            fwd[k][0] = 0; fwd[k][1] = 0; mon_xfer[k] = 0;
        end
    endtask

    initial begin
        int n, base_fwd, base_mon;
        logic [255:0] first_data;
        int exp_rr [6];
        int exp_sp [6];
        exp_rr = '{1, 2, 1, 2, 1, 2};
        exp_sp = '{1, 1, 1, 2, 2, 2};
        rst_n = 1'b0;
        l4r[0] = 1'b1;
        l4r[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(0, "reset_valid_lit", l4_valid[0], 0);
        chk(0, "reset_drop_lit", drop[0], 0);
        do_reset();

        // Lone 2-beat ARP packet: one bubble, two beats through, count 1
        @(negedge clk);
        push_pkt(0, 2, 0, 1'b1);
        n = 0;
        while (!s_valid[0] && n < 20) begin @(negedge clk); n++; end
        first_data = s_data[0];
        chk(0, "bubble_gnt", g_a[0], 0);
        chk(0, "bubble_valid", l4_valid[0], 0);
        @(negedge clk);
        chk(0, "first_gnt", g_a[0], 1);
        chk(0, "first_valid", l4_valid[0], 1);
        chk(0, "first_data", l4_data[0], first_data);
        drain(100);
        chk(0, "arp2_pkt_lit", pkt_a[0], 1);
        chk(0, "arp2_beats_lit", mon_xfer[0], 2);
        chk(0, "arp2_idle_lit", g_a[0], 0);

        // Simultaneous 3+3 packets: alternating on dut0, ARP-first on dut1
        do_reset();
        @(negedge clk);
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++) push_pkt(i, 2, 0, 1'b1);
        drain(400);
        chk(0, "rr_order_len", glog[0].size(), 6);
        chk(1, "sp_order_len", glog[1].size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < glog[0].size()) chk(0, $sformatf("rr_order_%0d", i), glog[0][i], exp_rr[i]);
            if (i < glog[1].size()) chk(1, $sformatf("sp_order_%0d", i), glog[1][i], exp_sp[i]);
        end
        for (int k = 0; k < 2; k++) begin
            chk(k, "both_pkt_arp_lit", pkt_a[k], 3);
            chk(k, "both_pkt_udp_lit", pkt_u[k], 3);
        end

        // Three stray UDP beats in IDLE are swallowed and counted
        do_reset();
        @(negedge clk);
        push_pkt(1, 1, 0, 1'b0);
        push_pkt(1, 1, 0, 1'b0);
        push_pkt(1, 1, 0, 1'b0);
        drain(100);
        chk(0, "stray_drop_lit", drop[0], 3);
        chk(0, "stray_fwd_lit", mon_xfer[0], 0);

        // 4-beat UDP packet under toggling MAC ready
        base_fwd = fwd[0][1];
        base_mon = mon_xfer[0];
        @(negedge clk);
        push_pkt(1, 4, 0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            l4r[0] = ~l4r[0];
        end
        l4r[0] = 1'b1;
        drain(200);
        chk(0, "toggle_model_beats", fwd[0][1] - base_fwd, 4);
        chk(0, "toggle_dut_beats", mon_xfer[0] - base_mon, 4);
        chk(0, "toggle_pkt_lit", pkt_u[0], 1);

        // Reset after beat 2 of a 4-beat ARP packet
        do_reset();
        @(negedge clk);
        push_pkt(0, 4, 0, 1'b1);
        n = 0;
        while (fwd[0][0] < 2 && n < 50) begin @(posedge clk); n++; end
        chk(0, "midrst_reached", fwd[0][0], 2);
        #1 rst_n = 1'b0;
        #1;
        chk(0, "midrst_valid", l4_valid[0], 0);
        chk(0, "midrst_gnt", g_a[0], 0);
        chk(0, "midrst_rdy_arp", s_ready[0], 0);
        chk(0, "midrst_rdy_udp", s_ready[1], 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drain(100);
        chk(0, "midrst_drop_lit", drop[0], 2);
        chk(0, "midrst_pkt_lit", pkt_a[0], 0);

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            for (int k = 0; k < 2; k++) l4r[k] = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (src_q[i].size() < 3 && $urandom_range(0, 15) == 0) begin
                    if ($urandom_range(0, 7) == 0)
                        push_pkt(i, 1, $urandom_range(0, 3), 1'b0);
                    else
                        push_pkt(i, $urandom_range(1, 5), $urandom_range(0, 3), 1'b1);
                end
            end
        end
        l4r[0] = 1'b1;
        l4r[1] = 1'b1;
        drain(5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
